// File: rtl/nanov_spi_pkg.sv
// Shared definitions for the nanoV SPI memory link: command opcodes,
// address field width and the responder state enumeration.
package nanov_spi_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam int         SPI_ADDR_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_READ   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_IGNORE = 3'd5
  } spi_state_e;

  // A transaction is in progress in every state except IDLE and IGNORE.
  function automatic logic state_is_busy(input spi_state_e s);
    return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_READ) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/nanov_spi_byte_ram.sv
// Byte array behind the SPI responder: asynchronous read, synchronous write.
// Kept as its own module so a technology macro can be dropped in later.
// Contents are deliberately not reset.
module nanov_spi_byte_ram #(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_BITS   = $clog2(DEPTH_BYTES)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [7:0]           rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  // Write port: one byte per enabled clock edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: combinational lookup so a byte can load on the same edge.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/nanov_spi_mem_responder.sv
// Device end of the nanoV SPI link. Decodes READ/WRITE + 24-bit address,
// then streams bytes out of (or into) a byte array with address
// auto-increment while select stays low. Bits are qualified by
// spi_clk_enable in the clk domain.
// Handshake: a bit transfers on a rising clk edge only when spi_select=0 and
// spi_clk_enable=1; with enable low every register holds, so the CPU may stop
// the bit clock at any point.
// DEPTH_BYTES must be a power of 2 and smaller than 2^24.
module nanov_spi_mem_responder
  import nanov_spi_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_BITS   = $clog2(DEPTH_BYTES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_select,
  input  logic                 spi_clk_enable,
  input  logic                 spi_in,
  output logic                 spi_out,
  output logic                 busy,
  output logic                 wr_strobe,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [7:0]           wr_data
);

  spi_state_e               state_q, state_d;
  logic [4:0]               bit_cnt_q;
  logic [SPI_ADDR_BITS-1:0] addr_q;
  logic                     is_write_q;
  logic [7:0]               shreg_q;
  logic                     spi_out_q;
  logic                     wr_strobe_q;
  logic [ADDR_BITS-1:0]     wr_addr_q;
  logic [7:0]               wr_data_q;

  logic                     bit_en;
  logic                     byte_done;
  logic                     addr_done;
  logic [7:0]               shift_in;
  logic [SPI_ADDR_BITS-1:0] addr_shift;
  logic [SPI_ADDR_BITS-1:0] addr_inc;
  logic [ADDR_BITS-1:0]     rd_idx;
  logic [7:0]               rd_data;
  logic                     ram_we;

  assign bit_en     = !spi_select && spi_clk_enable;
  assign byte_done  = (bit_cnt_q == 5'd7);
  assign addr_done  = (bit_cnt_q == 5'd23);
  assign shift_in   = {shreg_q[6:0], spi_in};
  assign addr_shift = {addr_q[SPI_ADDR_BITS-2:0], spi_in};
  // Only the array index bits advance; upper address bits are carried along.
  assign addr_inc   = {addr_q[SPI_ADDR_BITS-1:ADDR_BITS],
                       addr_q[ADDR_BITS-1:0] + ADDR_BITS'(1)};
  // The byte to load is either the one just addressed (last address bit)
  // or the next one in the stream (last bit of the current byte).
  assign rd_idx     = (state_q == ST_ADDR) ? addr_shift[ADDR_BITS-1:0]
                                           : addr_inc[ADDR_BITS-1:0];
  assign ram_we     = (state_q == ST_WRITE) && bit_en && byte_done;

  nanov_spi_byte_ram #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .ADDR_BITS  (ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(addr_q[ADDR_BITS-1:0]),
    .wdata(shift_in),
    .raddr(rd_idx),
    .rdata(rd_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; deselect wins from any state.
  always_comb begin
    state_d = state_q;
    if (spi_select) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD: begin
          if (bit_en && byte_done) begin
            if (shift_in == SPI_CMD_READ || shift_in == SPI_CMD_WRITE) state_d = ST_ADDR;
            else                                                       state_d = ST_IGNORE;
          end
        end
        ST_ADDR: begin
          if (bit_en && addr_done) state_d = is_write_q ? ST_WRITE : ST_READ;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs derived from state and the datapath registers.
  always_comb begin
    busy      = state_is_busy(state_q);
    spi_out   = spi_out_q;
    wr_strobe = wr_strobe_q;
    wr_addr   = wr_addr_q;
    wr_data   = wr_data_q;
  end

  // Datapath: bit counter, shift register, address and write reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= 5'd0;
      addr_q      <= '0;
      is_write_q  <= 1'b0;
      shreg_q     <= 8'd0;
      spi_out_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (spi_select) begin
        bit_cnt_q <= 5'd0;
        spi_out_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            spi_out_q <= 1'b0;
            if (bit_en) begin
              shreg_q   <= shift_in;
              bit_cnt_q <= 5'd1;
            end else begin
              bit_cnt_q <= 5'd0;
            end
          end
          ST_CMD: begin
            if (bit_en) begin
              shreg_q <= shift_in;
              if (byte_done) begin
                bit_cnt_q  <= 5'd0;
                is_write_q <= (shift_in == SPI_CMD_WRITE);
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          ST_ADDR: begin
            if (bit_en) begin
              addr_q <= addr_shift;
              if (addr_done) begin
                bit_cnt_q <= 5'd0;
                if (!is_write_q) begin
                  shreg_q   <= rd_data;
                  spi_out_q <= rd_data[7];
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          ST_READ: begin
            if (bit_en) begin
              if (byte_done) begin
                bit_cnt_q <= 5'd0;
                addr_q    <= addr_inc;
                shreg_q   <= rd_data;
                spi_out_q <= rd_data[7];
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
                shreg_q   <= {shreg_q[6:0], shreg_q[7]};
                spi_out_q <= shreg_q[6];
              end
            end
          end
          ST_WRITE: begin
            if (bit_en) begin
              shreg_q <= shift_in;
              if (byte_done) begin
                bit_cnt_q   <= 5'd0;
                addr_q      <= addr_inc;
                wr_strobe_q <= 1'b1;
                wr_addr_q   <= addr_q[ADDR_BITS-1:0];
                wr_data_q   <= shift_in;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          default: spi_out_q <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nanov_spi_mem_responder.sv
// Bench for nanov_spi_mem_responder: directed scenarios plus randomized
// read/write transactions checked against a byte-array model of the memory.
module tb_nanov_spi_mem_responder;

  localparam int DEPTH = 256;
  localparam int AB    = 8;

  logic          clk;
  logic          rst;
  logic          spi_select;
  logic          spi_clk_enable;
  logic          spi_in;
  logic          spi_out;
  logic          busy;
  logic          wr_strobe;
  logic [AB-1:0] wr_addr;
  logic [7:0]    wr_data;

  logic [7:0] mem_model [DEPTH];
  int n_cmp = 0;
  int n_err = 0;

  nanov_spi_mem_responder #(.DEPTH_BYTES(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .spi_select    (spi_select),
    .spi_clk_enable(spi_clk_enable),
    .spi_in        (spi_in),
    .spi_out       (spi_out),
    .busy          (busy),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks.
  task automatic send_bit(input logic b);
    spi_select     = 1'b0;
    spi_clk_enable = 1'b1;
    spi_in         = b;
    tick();
  endtask

  task automatic deselect();
    spi_select     = 1'b1;
    spi_clk_enable = 1'($urandom_range(0, 1));
    spi_in         = 1'($urandom_range(0, 1));
    tick();
    chk("desel_busy", busy, 1'b0);
    chk("desel_spi_out", spi_out, 1'b0);
    chk("desel_wr_strobe", wr_strobe, 1'b0);
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [23:0] addr);
    logic [31:0] hdr;
    logic        valid;
    hdr   = {cmd, addr};
    valid = (cmd == 8'h03) || (cmd == 8'h02);
    if ($urandom_range(0, 1) == 1) begin
      // Select drops without a bit: must still leave IDLE.
      spi_select     = 1'b0;
      spi_clk_enable = 1'b0;
      tick();
      chk("sel_no_bit_busy", busy, 1'b1);
    end
    for (int i = 31; i >= 0; i--) begin
      send_bit(hdr[i]);
      chk("hdr_busy", busy, (i > 24) ? 1'b1 : valid);
      if (!(i == 0 && cmd == 8'h03)) chk("hdr_spi_out", spi_out, 1'b0);
      chk("hdr_wr_strobe", wr_strobe, 1'b0);
    end
  endtask

  // Reads nbytes starting at addr; gap_bit (>=0) inserts gap_len disabled
  // cycles before that bit; rand_gaps sprinkles short gaps.
  task automatic read_stream(input logic [23:0] addr, input int nbytes,
                             input int gap_bit, input int gap_len, input bit rand_gaps);
    logic [7:0] exp;
    int         glen;
    for (int j = 0; j < nbytes; j++) begin
      exp = mem_model[(int'(addr[AB-1:0]) + j) % DEPTH];
      for (int k = 7; k >= 0; k--) begin
        chk("rd_bit", spi_out, exp[k]);
        chk("rd_busy", busy, 1'b1);
        glen = 0;
        if (j * 8 + (7 - k) == gap_bit) glen = gap_len;
        else if (rand_gaps && $urandom_range(0, 7) == 0) glen = $urandom_range(1, 3);
        for (int g = 0; g < glen; g++) begin
          spi_select     = 1'b0;
          spi_clk_enable = 1'b0;
          spi_in         = 1'($urandom_range(0, 1));
          tick();
          chk("gap_hold", spi_out, exp[k]);
        end
        send_bit(1'($urandom_range(0, 1)));
        chk("rd_wr_strobe", wr_strobe, 1'b0);
      end
    end
  endtask

  task automatic write_byte(input logic [7:0] d, input logic [AB-1:0] a);
    for (int k = 7; k >= 0; k--) begin
      send_bit(d[k]);
      chk("wr_spi_out", spi_out, 1'b0);
      if (k == 0) begin
        chk("wr_strobe_hi", wr_strobe, 1'b1);
        chk("wr_addr", wr_addr, a);
        chk("wr_data", wr_data, d);
        mem_model[a] = d;
      end else begin
        chk("wr_strobe_lo", wr_strobe, 1'b0);
      end
    end
  endtask

  task automatic write_txn(input logic [23:0] addr, input int nbytes, input logic [7:0] fixed0,
                           input logic [7:0] fixed1, input bit use_fixed);
    logic [AB-1:0] a;
    logic [7:0]    d;
    send_header(8'h02, addr);
    a = addr[AB-1:0];
    for (int j = 0; j < nbytes; j++) begin
      if (use_fixed) d = (j == 0) ? fixed0 : fixed1;
      else           d = 8'($urandom_range(0, 255));
      write_byte(d, a);
      a = a + 1'b1;
    end
  endtask

  task automatic read_txn(input logic [23:0] addr, input int nbytes, input int gap_bit,
                          input int gap_len, input bit rand_gaps);
    send_header(8'h03, addr);
    read_stream(addr, nbytes, gap_bit, gap_len, rand_gaps);
    deselect();
  endtask

  // Stimulus and final report.
  initial begin
    logic [23:0] a;
    rst            = 1'b1;
    spi_select     = 1'b1;
    spi_clk_enable = 1'b0;
    spi_in         = 1'b0;
    repeat (3) tick();
    chk("rst_spi_out", spi_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_strobe", wr_strobe, 1'b0);
    chk("rst_wr_addr", wr_addr, '0);
    chk("rst_wr_data", wr_data, 8'd0);
    rst = 1'b0;
    tick();

    // Fill the whole array so every later read has a known value.
    write_txn({16'($urandom_range(0, 65535)), 8'h00}, DEPTH, 8'h00, 8'h00, 1'b0);
    deselect();

    // Directed: preload 0xA5 0x3C at 0x10 and stream them back.
    write_txn(24'h000010, 2, 8'hA5, 8'h3C, 1'b1);
    deselect();
    read_txn(24'h000010, 2, -1, 0, 1'b0);

    // Directed: write DE AD at 0x20, read back.
    write_txn(24'h000020, 2, 8'hDE, 8'hAD, 1'b1);
    deselect();
    read_txn(24'h000020, 2, -1, 0, 1'b0);

    // Wrap: read from 0xFF, second byte from 0x00.
    read_txn(24'h0000FF, 2, -1, 0, 1'b0);

    // Partial second byte is discarded on deselect.
    a = 24'($urandom_range(0, 24'hFFFFFF));
    send_header(8'h02, a);
    write_byte(8'hFF, a[AB-1:0]);
    for (int k = 0; k < 4; k++) begin
      send_bit(1'($urandom_range(0, 1)));
      chk("partial_wr_strobe", wr_strobe, 1'b0);
    end
    deselect();
    read_txn(a, 2, -1, 0, 1'b0);

    // Unknown command: silent for 40 more bits, then a normal read.
    send_header(8'h9F, 24'($urandom_range(0, 24'hFFFFFF)));
    for (int k = 0; k < 40; k++) begin
      send_bit(1'($urandom_range(0, 1)));
      chk("ign_spi_out", spi_out, 1'b0);
      chk("ign_wr_strobe", wr_strobe, 1'b0);
      chk("ign_busy", busy, 1'b0);
    end
    deselect();
    read_txn(24'($urandom_range(0, 24'hFFFFFF)), 2, -1, 0, 1'b0);

    // Clock gap of 5 cycles mid-byte.
    read_txn(24'($urandom_range(0, 24'hFFFFFF)), 2, 4, 5, 1'b0);

    // Randomized mix of reads and writes.
    for (int t = 0; t < 24; t++) begin
      a = 24'($urandom_range(0, 24'hFFFFFF));
      if ($urandom_range(0, 1) == 1) begin
        write_txn(a, $urandom_range(1, 4), 8'h00, 8'h00, 1'b0);
        deselect();
      end else begin
        read_txn(a, $urandom_range(1, 4), -1, 0, 1'b1);
      end
    end

    // Asynchronous reset in the middle of a read stream.
    a = 24'($urandom_range(0, 24'hFFFFFF));
    send_header(8'h03, a);
    read_stream(a, 1, -1, 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_spi_out", spi_out, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_wr_strobe", wr_strobe, 1'b0);
    spi_select     = 1'b1;
    spi_clk_enable = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    // Array survives reset.
    read_txn(a, 3, -1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
